// File: rtl/fewcore_pkg.sv
// Shared types and constants for the fewcore pipeline control blocks.
package fewcore_pkg;

  localparam int RADDR_W = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] rd;
    logic               is_load;
  } slot_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Hazard controller for the fetch/decode -> execute -> write pipeline: forwarding
// selects, load-use stall, branch flush and saturating perf counters.
module hazard_scheduler #(
  parameter int RADDR_W      = fewcore_pkg::RADDR_W,
  parameter int NREG         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic               id_writes_rd,
  input  logic               id_is_load,
  input  logic               ex_branch_taken,
  output logic               issue,
  output logic               stall,
  output logic               flush,
  output logic [1:0]         fwd_rs1_sel,
  output logic [1:0]         fwd_rs2_sel,
  output logic [NREG-1:0]    busy_map,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);
  import fewcore_pkg::*;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  slot_t        ex_slot, wb_slot;
  sched_state_t state, state_next;
  logic [1:0]   flush_left, flush_left_next;

  logic rs1_ex_hit, rs1_wb_hit, rs2_ex_hit, rs2_wb_hit;
  logic load_use, flush_raw, stall_raw;

  // x0 never matches so a write to it can neither forward nor stall.
  assign rs1_ex_hit = id_uses_rs1 && ex_slot.valid && (ex_slot.rd == id_rs1) && (id_rs1 != '0);
  assign rs1_wb_hit = id_uses_rs1 && wb_slot.valid && (wb_slot.rd == id_rs1) && (id_rs1 != '0);
  assign rs2_ex_hit = id_uses_rs2 && ex_slot.valid && (ex_slot.rd == id_rs2) && (id_rs2 != '0);
  assign rs2_wb_hit = id_uses_rs2 && wb_slot.valid && (wb_slot.rd == id_rs2) && (id_rs2 != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      flush_left <= '0;
      ex_slot    <= '0;
      wb_slot    <= '0;
    end else begin
      state      <= state_next;
      flush_left <= flush_left_next;
      wb_slot    <= ex_slot;
      ex_slot    <= issue ? '{valid: id_writes_rd && (id_rd != '0), rd: id_rd, is_load: id_is_load}
                          : '0;
    end
  end

  always_comb begin
    state_next      = state;
    flush_left_next = flush_left;
    fwd_rs1_sel     = FWD_RF;
    fwd_rs2_sel     = FWD_RF;

    case (state)
      ST_RUN: begin
        if (ex_branch_taken && (FLUSH_CYCLES > 1)) begin
          state_next      = ST_FLUSH;
          flush_left_next = FLUSH_RELOAD;
        end
      end
      ST_FLUSH: begin
        if (ex_branch_taken) begin
          flush_left_next = FLUSH_RELOAD;
        end else if (flush_left <= 2'd1) begin
          state_next      = ST_RUN;
          flush_left_next = '0;
        end else begin
          flush_left_next = flush_left - 2'd1;
        end
      end
      default: begin
        state_next      = ST_RUN;
        flush_left_next = '0;
      end
    endcase

    // A load in execute has no result yet, so only the write stage can forward.
    if (rs1_ex_hit && !ex_slot.is_load) fwd_rs1_sel = FWD_EX;
    else if (rs1_wb_hit)                fwd_rs1_sel = FWD_WB;
    if (rs2_ex_hit && !ex_slot.is_load) fwd_rs2_sel = FWD_EX;
    else if (rs2_wb_hit)                fwd_rs2_sel = FWD_WB;

    load_use  = id_valid && ex_slot.is_load && (rs1_ex_hit || rs2_ex_hit);
    flush_raw = ex_branch_taken || (state == ST_FLUSH);
    stall_raw = load_use && !flush_raw;

    flush = flush_raw && !reset;
    stall = stall_raw && !reset;
    issue = id_valid && !stall_raw && !flush_raw && !reset;
  end

  always_comb begin
    busy_map = '0;
    for (int i = 1; i < NREG; i++) begin
      busy_map[i] = (ex_slot.valid && (ex_slot.rd == RADDR_W'(i))) ||
                    (wb_slot.valid && (wb_slot.rd == RADDR_W'(i)));
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: a behavioural model queues the expected
// outputs for each driven cycle and they are popped and compared mid-cycle.
module tb_hazard_scheduler;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_writes_rd = 1'b0, id_is_load = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic        issue, stall, flush;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] busy_map;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_scheduler #(.RADDR_W(5), .NREG(32), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_writes_rd    (id_writes_rd),
    .id_is_load      (id_is_load),
    .ex_branch_taken (ex_branch_taken),
    .issue           (issue),
    .stall           (stall),
    .flush           (flush),
    .fwd_rs1_sel     (fwd_rs1_sel),
    .fwd_rs2_sel     (fwd_rs2_sel),
    .busy_map        (busy_map),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  ctrl;
    logic [31:0] busy;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t expq[$];
  int   check_count = 0;
  int   pass_count = 0;

  bit       m_ex_valid, m_ex_load, m_wb_valid, m_fsm_flush;
  bit [4:0] m_ex_rd, m_wb_rd;
  int       m_left, m_scnt, m_fcnt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    else
      pass_count++;
  endtask

  task automatic modelReset();
    m_ex_valid = 0; m_ex_load = 0; m_ex_rd = '0;
    m_wb_valid = 0; m_wb_rd = '0;
    m_fsm_flush = 0; m_left = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  // One clock cycle: drive inputs, queue the model's expectation, compare at the
  // falling edge, then advance the model across the rising edge.
  task automatic applyStimulus(input bit rst, input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                               input bit [4:0] rd, input bit u1, input bit u2, input bit wr,
                               input bit ld, input bit br, input bit chk);
    bit e1, e2, w1, w2, lu, fl, st, is;
    bit [1:0] f1, f2;
    logic [31:0] bm;
    exp_t e, got;
    reset = rst; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_writes_rd = wr; id_is_load = ld; ex_branch_taken = br;

    e1 = u1 && m_ex_valid && (m_ex_rd == rs1) && (rs1 != 0);
    w1 = u1 && m_wb_valid && (m_wb_rd == rs1) && (rs1 != 0);
    e2 = u2 && m_ex_valid && (m_ex_rd == rs2) && (rs2 != 0);
    w2 = u2 && m_wb_valid && (m_wb_rd == rs2) && (rs2 != 0);
    f1 = (e1 && !m_ex_load) ? 2'b01 : (w1 ? 2'b10 : 2'b00);
    f2 = (e2 && !m_ex_load) ? 2'b01 : (w2 ? 2'b10 : 2'b00);
    lu = v && m_ex_load && (e1 || e2);
    fl = br || m_fsm_flush;
    st = lu && !fl;
    is = v && !st && !fl;
    if (rst) begin fl = 0; st = 0; is = 0; end
    bm = '0;
    if (m_ex_valid) bm[m_ex_rd] = 1'b1;
    if (m_wb_valid) bm[m_wb_rd] = 1'b1;
    e.ctrl = {is, st, fl, f1, f2};
    e.busy = bm;
    e.scnt = 16'(m_scnt);
    e.fcnt = 16'(m_fcnt);
    if (chk) expq.push_back(e);

    @(negedge clk);
    if (chk) begin
      if (expq.size() == 0) begin
        checkOutput("queue_empty", 32'd0, 32'd1);
      end else begin
        got = expq.pop_front();
        checkOutput("ctrl{issue,stall,flush,fwd1,fwd2}",
                    {25'd0, issue, stall, flush, fwd_rs1_sel, fwd_rs2_sel}, {25'd0, got.ctrl});
        checkOutput("busy_map", busy_map, got.busy);
        checkOutput("stall_cnt", {16'd0, stall_cnt}, {16'd0, got.scnt});
        checkOutput("flush_cnt", {16'd0, flush_cnt}, {16'd0, got.fcnt});
      end
    end

    if (rst) begin
      modelReset();
    end else begin
      m_wb_valid = m_ex_valid; m_wb_rd = m_ex_rd;
      m_ex_valid = is && wr && (rd != 0);
      m_ex_rd    = is ? rd : 5'd0;
      m_ex_load  = is && ld;
      if (st && m_scnt < 65535) m_scnt++;
      if (fl && m_fcnt < 65535) m_fcnt++;
      if (!m_fsm_flush) begin
        if (br && FC > 1) begin m_fsm_flush = 1; m_left = FC - 1; end
      end else if (br) begin
        m_left = FC - 1;
      end else if (m_left <= 1) begin
        m_fsm_flush = 0; m_left = 0;
      end else begin
        m_left--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] hazard_scheduler bench start");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // args: rst v rs1 rs2 rd u1 u2 wr ld br chk
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // back-to-back ALU dependency
    applyStimulus(0, 1, 0, 0, 5, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 5, 0, 0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 5, 0, 0, 1, 0, 0, 0, 1);
    // load-use, held instruction retried after one stall
    applyStimulus(0, 1, 0, 0, 7, 0, 0, 1, 1, 0, 1);
    applyStimulus(0, 1, 0, 7, 8, 0, 1, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 7, 8, 0, 1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // x0 guard
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    // branch with two-cycle flush
    applyStimulus(0, 1, 1, 2, 3, 1, 1, 1, 0, 1, 1);
    applyStimulus(0, 1, 1, 2, 3, 1, 1, 1, 0, 0, 1);
    applyStimulus(0, 1, 1, 2, 3, 1, 1, 1, 0, 0, 1);
    // branch coinciding with load-use
    applyStimulus(0, 1, 0, 0, 9, 0, 0, 1, 1, 0, 1);
    applyStimulus(0, 1, 9, 0, 4, 1, 0, 1, 0, 1, 1);
    applyStimulus(0, 1, 9, 0, 4, 1, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // both slots hold rd=3: younger wins
    applyStimulus(0, 1, 0, 0, 3, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 3, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 3, 3, 0, 1, 1, 0, 0, 0, 1);
    // load in ex over an ALU write in wb of the same register
    applyStimulus(0, 1, 0, 0, 4, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 4, 0, 0, 1, 1, 0, 1);
    applyStimulus(0, 1, 4, 0, 0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 4, 0, 0, 1, 0, 0, 0, 0, 1);
    // reset in the middle of a flush
    applyStimulus(0, 1, 0, 0, 6, 0, 0, 1, 0, 1, 1);
    applyStimulus(1, 1, 0, 0, 6, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 6, 0, 0, 1, 0, 0, 0, 0, 1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 9) == 0, 1);
    end

    // continuous branching drives flush_cnt to saturation
    for (int i = 0; i < 65539; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    end
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("flush_cnt_saturated", {16'd0, flush_cnt}, 32'h0000_FFFF);

    // reset in the middle of a load-use stall
    applyStimulus(0, 1, 0, 0, 6, 0, 0, 1, 1, 0, 1);
    applyStimulus(0, 1, 6, 0, 0, 1, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 6, 0, 0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 6, 0, 0, 1, 0, 0, 0, 0, 1);
    checkOutput("post_reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    checkOutput("post_reset_busy_map", busy_map, 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
